// File: rtl/seq_det_pkg.sv
// seq_det_pkg: reset defaults plus length-clamp and low-bit masking helpers for the pattern detector.
package seq_det_pkg;
    localparam int SEQ_MAX_W = 64;
    localparam logic [SEQ_MAX_W-1:0] SEQ_DEF_PATTERN = 64'b101;
    localparam int SEQ_DEF_LEN = 3;
    localparam bit SEQ_DEF_OVERLAP = 1'b1;

    function automatic int clamp_len(input int len, input int max_len);
        return (len < 1) ? 1 : (len > max_len) ? max_len : len;
    endfunction

    function automatic logic [SEQ_MAX_W-1:0] low_bits(input logic [SEQ_MAX_W-1:0] v, input int len);
        return (len >= SEQ_MAX_W) ? v : v & ((64'd1 << len) - 64'd1);
    endfunction
endpackage

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: saturating up-counter where clear applies first and a same-edge increment still counts.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (clr) count <= CNT_W'(inc);
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with registered match pulse and counter.
// Define SEQ_DETECTOR_MEALY_OUT_EN to drive match_early with the same-cycle combinational hit.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN+1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
    parameter int                 DEF_LEN     = SEQ_DEF_LEN,
    parameter bit                 DEF_OVERLAP = SEQ_DEF_OVERLAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               match_early
);
    localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern, history, candidate;
    logic [LEN_W-1:0]   len, fill;
    logic               overlap, hit, accept;

    assign candidate = {history[MAX_LEN-2:0], in_bit};
    assign hit = in_valid && ({1'b0, fill} + 1'b1 >= {1'b0, len}) &&
                 low_bits(SEQ_MAX_W'(candidate ^ pattern), int'(len)) == '0;
    // A bit arriving together with cfg_load is discarded, so it can never hit.
    assign accept = hit && !cfg_load;

`ifdef SEQ_DETECTOR_MEALY_OUT_EN
    assign match_early = accept && !rst;
`else
    assign match_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= DEF_PATTERN;
            len     <= RST_LEN;
            overlap <= DEF_OVERLAP;
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            overlap <= cfg_overlap;
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (in_valid) begin
                history <= candidate;
                fill    <= (hit && !overlap) ? '0 : (fill == FULL) ? fill : fill + 1'b1;
            end
        end
    end

    seq_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clr   (count_clr),
        .count (match_count)
    );
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector, successor to the fixed 4-state "101" overlapping detector.
- Pattern, length (1..MAX_LEN) and overlap mode are run-time programmable.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial bit stream in front of control or status logic that consumes single-cycle match pulses.

Parameters:
- MAX_LEN, 8, widest supported pattern in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len.
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 'b101, pattern loaded at reset (MAX_LEN bits, right-aligned).
- DEF_LEN, 3, length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset.
- cfg_load, input, 1, load cfg_pattern/cfg_len/cfg_overlap this edge.
- cfg_pattern, input, MAX_LEN, pattern; bit len-1 is the first bit received.
- cfg_len, input, LEN_W, pattern length.
- cfg_overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- in_valid, input, 1, in_bit is sampled only when high.
- in_bit, input, 1, serial data bit.
- count_clr, input, 1, synchronous clear of match_count.
- match, output, 1, registered one-cycle match pulse.
- match_count, output, CNT_W, saturating count of matches.
- match_early, output, 1, combinational match; see Optional Feature.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values:
  - Config registers load DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
  - history = 0, fill = 0, match = 0, match_count = 0.
  - Reset overrides every other input.
- Length clamp on load: cfg_len = 0 loads 1; cfg_len > MAX_LEN loads MAX_LEN.
- history: MAX_LEN-bit shift register. On an accepted bit, history <= {history[MAX_LEN-2:0], in_bit}.
- fill: count of valid bits since the last clear; saturates at MAX_LEN.
- Hit (per accepted bit):
  - Requires in_valid & (fill+1 >= len) & (candidate[len-1:0] == pattern[len-1:0]).
  - candidate = {history[MAX_LEN-2:0], in_bit}.
- Latency: match is high in the cycle after the edge that accepts the last pattern bit, for exactly one cycle; otherwise 0.
- in_valid low: history, fill and count hold; match goes 0 next cycle. Gaps never break a partial sequence.
- Overlap = 1: after a hit, fill continues to increment/saturate, so trailing bits may begin the next match ("10101" with "101" gives 2 hits).
- Overlap = 0: a hit clears fill to 0; the next match needs len fresh valid bits.
- cfg_load:
  - Config takes effect for bits accepted after this edge.
  - Same edge: history and fill cleared, match driven 0.
  - If in_valid is high on the same edge, cfg_load wins and the bit is discarded.
- match_count:
  - +1 on each registered hit; saturates at 2^CNT_W-1, no wrap.
  - count_clr alone: count becomes 0.
  - count_clr with a hit on the same edge: count becomes 1.
  - Unaffected by cfg_load.
- No internal FSM encoding beyond history/fill. Equivalent behaviour to the legacy detector at the default parameters, with the output delayed one cycle after the third bit.

Optional Feature:
- Macro: SEQ_DETECTOR_MEALY_OUT_EN.
- Defined: match_early = the combinational hit term above, asserted in the same cycle the final bit is presented (Mealy style). It is gated low during rst and cfg_load.
- Undefined: match_early is tied 0; no combinational path from in_bit to an output.

Decomposition:
- Package seq_det_pkg:
  - Length-clamp function.
  - Defaults for DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
  - Masking function returning the low len bits of a MAX_LEN vector.
- Sub-module seq_sat_counter (CNT_W parameter; inc, clr, count; clr-then-inc semantics) implements match_count.
- Shift/compare logic stays in the top module.

Test Plan:
- Defaults ("101", overlap), continuous valid, stream 1,0,1,0,1,0,1 -> match pulses one cycle after bits 3, 5, 7; match_count = 3.
- Load len 3 "101", overlap 0, same stream -> pulses after bits 3 and 7 only; count = 2.
- Load 8'b11010011, len 8, feed bits with in_valid low for 2 cycles between bits 4 and 5 -> single pulse one cycle after the 8th valid bit; no pulse during gaps.
- Stream 1,0; cfg_load (same "101") with in_valid = 1, in_bit = 1 on that edge; then 1 -> no match (history cleared, bit dropped); then 0,1 -> match after that last 1. cfg_len = 0 load -> len 1, every matching single bit pulses.
- CNT_W = 2, 5 hits -> match_count = 3 (saturated); count_clr on an edge coinciding with a hit -> count = 1.
- rst asserted on the edge that would register a hit -> match = 0, match_count = 0, config restored to "101"/3/overlap. With SEQ_DETECTOR_MEALY_OUT_EN: match_early high in the same cycle as the 3rd bit of "101", one cycle before match.
